// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, round counts, engine FSM states and GF(2^8) byte helpers.
package aes_pkg;

    localparam int AES_BLK_W  = 128;
    localparam int AES_NR_128 = 10;
    localparam int AES_NR_192 = 12;
    localparam int AES_NR_256 = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            acc = b[i] ? (acc ^ p) : acc;
            p   = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            r = (i > 0) ? gf_mul(r, p) : r;
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_round_dp.sv
// Combinational AES round: SubBytes, ShiftRows, MixColumns (skipped when final_rnd), AddRoundKey.
module aes_round_dp
    import aes_pkg::*;
(
    input  logic [AES_BLK_W-1:0] state_in,
    input  logic [AES_BLK_W-1:0] round_key,
    input  logic                 final_rnd,
    output logic [AES_BLK_W-1:0] state_out
);

    logic [7:0] sb_s [16];
    logic [7:0] sr_s [16];
    logic [7:0] mc_s [16];

    // SubBytes; byte k sits at row k%4, column k/4 with byte 0 in the top bits.
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            sb_s[k] = sbox(state_in[127-8*k -: 8]);
        end
    end

    // ShiftRows rotates row r left by r columns.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_s[4*c+r] = sb_s[4*((c+r)%4)+r];
            end
        end
    end

    // MixColumns with the {02,03,01,01} circulant matrix.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc_s[4*c+0] = xtime(sr_s[4*c+0]) ^ xtime(sr_s[4*c+1]) ^ sr_s[4*c+1] ^ sr_s[4*c+2] ^ sr_s[4*c+3];
            mc_s[4*c+1] = sr_s[4*c+0] ^ xtime(sr_s[4*c+1]) ^ xtime(sr_s[4*c+2]) ^ sr_s[4*c+2] ^ sr_s[4*c+3];
            mc_s[4*c+2] = sr_s[4*c+0] ^ sr_s[4*c+1] ^ xtime(sr_s[4*c+2]) ^ xtime(sr_s[4*c+3]) ^ sr_s[4*c+3];
            mc_s[4*c+3] = xtime(sr_s[4*c+0]) ^ sr_s[4*c+0] ^ sr_s[4*c+1] ^ sr_s[4*c+2] ^ xtime(sr_s[4*c+3]);
        end
    end

    // AddRoundKey on either the mixed or the unmixed (final round) state.
    always_comb begin
        state_out = '0;
        for (int k = 0; k < 16; k++) begin
            state_out[127-8*k -: 8] = (final_rnd ? sr_s[k] : mc_s[k]) ^ round_key[127-8*k -: 8];
        end
    end

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES encryption engine: one round per clock, round keys fetched by index each cycle.
// Define AES_ROUND_ENGINE_DBG_EN to add the dbg_valid/dbg_round/dbg_state trace outputs.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int RKI_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_block,
    output logic [RKI_W-1:0]     rk_idx,
    input  logic [AES_BLK_W-1:0] rk_data,
`ifdef AES_ROUND_ENGINE_DBG_EN
    output logic                 dbg_valid,
    output logic [RKI_W-1:0]     dbg_round,
    output logic [AES_BLK_W-1:0] dbg_state,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_block
);

    generate
        if (!(NUM_ROUNDS == AES_NR_128 || NUM_ROUNDS == AES_NR_192 || NUM_ROUNDS == AES_NR_256)) begin : g_bad_nr
            $error("aes_round_engine: NUM_ROUNDS must be 10, 12 or 14");
        end
        if ((2 ** RKI_W) <= NUM_ROUNDS) begin : g_bad_rki
            $error("aes_round_engine: RKI_W too narrow for NUM_ROUNDS");
        end
    endgenerate

    localparam logic [RKI_W-1:0] LAST_RND = RKI_W'(NUM_ROUNDS);

    aes_fsm_e               fsm_r;
    logic [RKI_W-1:0]       ctr_r;
    logic [AES_BLK_W-1:0]   state_r;
    logic                   out_valid_r;
    logic [AES_BLK_W-1:0]   dp_out_s;
    logic [AES_BLK_W-1:0]   state_nxt_s;
    logic                   state_upd_s;
    logic                   accept_s;
    logic                   final_s;

    assign in_ready  = (fsm_r == IDLE) | ((fsm_r == DONE) & out_ready);
    assign accept_s  = in_valid & in_ready;
    assign final_s   = (ctr_r == LAST_RND);
    // ctr_r is cleared outside RUN, so it doubles as the round-key index.
    assign rk_idx    = ctr_r;
    assign out_valid = out_valid_r;
    assign out_block = state_r;

    aes_round_dp u_dp (
        .state_in  (state_r),
        .round_key (rk_data),
        .final_rnd (final_s),
        .state_out (dp_out_s)
    );

    // Next state value: key whitening on accept, one cipher round while running.
    always_comb begin
        state_upd_s = 1'b0;
        state_nxt_s = state_r;
        if (accept_s) begin
            state_upd_s = 1'b1;
            state_nxt_s = in_block ^ rk_data;
        end else if (fsm_r == RUN) begin
            state_upd_s = 1'b1;
            state_nxt_s = dp_out_s;
        end else begin
            state_upd_s = 1'b0;
            state_nxt_s = state_r;
        end
    end

    // Control FSM, round counter and state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r       <= IDLE;
            ctr_r       <= '0;
            state_r     <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (state_upd_s) begin
                state_r <= state_nxt_s;
            end
            case (fsm_r)
                IDLE: begin
                    if (accept_s) begin
                        fsm_r <= RUN;
                        ctr_r <= RKI_W'(1);
                    end
                end
                RUN: begin
                    if (final_s) begin
                        fsm_r       <= DONE;
                        ctr_r       <= '0;
                        out_valid_r <= 1'b1;
                    end else begin
                        ctr_r <= ctr_r + RKI_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (in_valid) begin
                            fsm_r <= RUN;
                            ctr_r <= RKI_W'(1);
                        end else begin
                            fsm_r <= IDLE;
                        end
                    end
                end
                default: begin
                    fsm_r       <= IDLE;
                    ctr_r       <= '0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef AES_ROUND_ENGINE_DBG_EN
    logic                 dbg_valid_r;
    logic [RKI_W-1:0]     dbg_round_r;
    logic [AES_BLK_W-1:0] dbg_state_r;

    assign dbg_valid = dbg_valid_r;
    assign dbg_round = dbg_round_r;
    assign dbg_state = dbg_state_r;

    // Trace every state register update alongside the round number it completed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_valid_r <= 1'b0;
            dbg_round_r <= '0;
            dbg_state_r <= '0;
        end else begin
            dbg_valid_r <= state_upd_s;
            dbg_round_r <= state_upd_s ? ctr_r : '0;
            dbg_state_r <= state_upd_s ? state_nxt_s : dbg_state_r;
        end
    end
`endif

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: an NR=10 and an NR=14 instance, a block-level AES model and FIPS-197 vectors.
module tb_aes_round_engine;

    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid  [2] = '{default: 1'b0};
    logic         in_ready  [2];
    logic [127:0] in_block  [2] = '{default: '0};
    logic [3:0]   rk_idx    [2];
    logic [127:0] rk_data   [2];
    logic         out_valid [2];
    logic         out_ready [2] = '{default: 1'b0};
    logic [127:0] out_block [2];
    logic [127:0] rks [2][16];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign rk_data[0] = rks[0][rk_idx[0]];
    assign rk_data[1] = rks[1][rk_idx[1]];

`ifdef AES_ROUND_ENGINE_DBG_EN
    logic         dbg_valid [2];
    logic [3:0]   dbg_round [2];
    logic [127:0] dbg_state [2];
    logic [127:0] dbg_r1 = '0;
    bit           dbg_r1_seen = 1'b0;
`endif

    aes_round_engine #(.NUM_ROUNDS(10), .RKI_W(4)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_block(in_block[0]), .rk_idx(rk_idx[0]), .rk_data(rk_data[0]),
`ifdef AES_ROUND_ENGINE_DBG_EN
        .dbg_valid(dbg_valid[0]), .dbg_round(dbg_round[0]), .dbg_state(dbg_state[0]),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_block(out_block[0])
    );

    aes_round_engine #(.NUM_ROUNDS(14), .RKI_W(4)) u_dut14 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_block(in_block[1]), .rk_idx(rk_idx[1]), .rk_data(rk_data[1]),
`ifdef AES_ROUND_ENGINE_DBG_EN
        .dbg_valid(dbg_valid[1]), .dbg_round(dbg_round[1]), .dbg_state(dbg_state[1]),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_block(out_block[1])
    );

    // ---------------- reference AES (log/antilog field arithmetic) ----------------
    logic [7:0] exp_t [256];
    int         log_t [256];

    function automatic void build_tables();
        logic [7:0] x;
        x = 8'h01;
        for (int k = 0; k < 255; k++) begin
            exp_t[k] = x;
            log_t[x] = k;
            x = x ^ {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
    endfunction

    function automatic logic [7:0] b_mul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    function automatic logic [7:0] b_sbox(input logic [7:0] x);
        logic [7:0] v, y, c;
        c = 8'h63;
        v = (x == 8'h00) ? 8'h00 : exp_t[(255 - log_t[x]) % 255];
        for (int k = 0; k < 8; k++)
            y[k] = v[k] ^ v[(k+4)%8] ^ v[(k+5)%8] ^ v[(k+6)%8] ^ v[(k+7)%8] ^ c[k];
        return y;
    endfunction

    function automatic int nr_of(input int i);
        return (i == 0) ? 10 : 14;
    endfunction

    task automatic expand_key(input int i, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int j = 0; j < nk; j++) w[j] = key[255-32*j -: 32];
        for (int j = nk; j < 4*(nk+7); j++) begin
            t = w[j-1];
            if (j % nk == 0) begin
                t = {t[23:0], t[31:24]};
                t = {b_sbox(t[31:24]), b_sbox(t[23:16]), b_sbox(t[15:8]), b_sbox(t[7:0])} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && j % nk == 4) begin
                t = {b_sbox(t[31:24]), b_sbox(t[23:16]), b_sbox(t[15:8]), b_sbox(t[7:0])};
            end
            w[j] = w[j-nk] ^ t;
        end
        for (int k = 0; k <= nk + 6; k++) rks[i][k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] pt, input int i);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   m [4];
        logic [7:0]   a;
        logic [127:0] k, o;
        int nr;
        m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        nr = nr_of(i);
        k = rks[i][0];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ k[127-8*(4*c+r) -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = b_sbox(s[r][(c+r)%4]);
            k = rks[i][rnd];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    a = t[r][c];
                    if (rnd < nr) begin
                        a = 8'h00;
                        for (int j = 0; j < 4; j++) a = a ^ b_mul(m[(j-r+4)%4], t[j][c]);
                    end
                    s[r][c] = a ^ k[127-8*(4*c+r) -: 8];
                end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    // ---------------- cycle-level expectation: busy count, result holding ----------------
    int           m_cnt  [2] = '{default: 0};
    bit           m_ov   [2] = '{default: 1'b0};
    logic [127:0] m_blk  [2] = '{default: '0};
    logic [127:0] m_pend [2] = '{default: '0};
    bit           m_dv   [2] = '{default: 1'b0};
    int           m_dr   [2] = '{default: 0};

    function automatic bit m_ready(input int i);
        return (m_cnt[i] == 0 && !m_ov[i]) || (m_ov[i] && out_ready[i]);
    endfunction

    // Advance the model on each clock, or clear it on reset.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_cnt[i] <= 0; m_ov[i] <= 1'b0; m_blk[i] <= '0; m_dv[i] <= 1'b0; m_dr[i] <= 0;
            end else begin
                m_dv[i] <= (in_valid[i] && m_ready(i)) || (m_cnt[i] != 0);
                m_dr[i] <= (in_valid[i] && m_ready(i)) ? 0 : m_cnt[i];
                if (in_valid[i] && m_ready(i)) begin
                    m_cnt[i] <= 1; m_ov[i] <= 1'b0; m_pend[i] <= model_enc(in_block[i], i);
                end else if (m_cnt[i] == nr_of(i)) begin
                    m_cnt[i] <= 0; m_ov[i] <= 1'b1; m_blk[i] <= m_pend[i];
                end else if (m_cnt[i] != 0) begin
                    m_cnt[i] <= m_cnt[i] + 1;
                end else if (m_ov[i] && out_ready[i]) begin
                    m_ov[i] <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model each cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("in_ready[%0d]", i), in_ready[i], m_ready(i));
            check($sformatf("out_valid[%0d]", i), out_valid[i], m_ov[i]);
            check($sformatf("rk_idx[%0d]", i), rk_idx[i], m_cnt[i]);
            if (m_cnt[i] == 0) check($sformatf("out_block[%0d]", i), out_block[i], m_blk[i]);
`ifdef AES_ROUND_ENGINE_DBG_EN
            check($sformatf("dbg_valid[%0d]", i), dbg_valid[i], m_dv[i]);
            if (m_dv[i]) check($sformatf("dbg_round[%0d]", i), dbg_round[i], m_dr[i]);
            if (i == 0 && m_dv[i] && m_dr[i] == 1 && !dbg_r1_seen) begin
                dbg_r1 <= dbg_state[0];
                dbg_r1_seen <= 1'b1;
            end
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_block(input int i, input logic [127:0] pt);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        @(posedge clk); #2;
        in_valid[i] = 1'b1;
        in_block[i] = pt;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = in_ready[i];
            n++;
            @(posedge clk); #2;
        end
        in_valid[i] = 1'b0;
        check("accept", acc, 1'b1);
    endtask

    // Latency counts the accept cycle as cycle 1.
    task automatic finish_block(input int i, input logic [127:0] exp, input int hold);
        int lat;
        bit done;
        lat = 1;
        done = 1'b0;
        while (!done && lat < 64) begin
            @(negedge clk);
            if (out_valid[i]) done = 1'b1;
            else begin
                @(posedge clk); #2;
                lat++;
            end
        end
        check("latency", lat, nr_of(i) + 1);
        check("ciphertext", out_block[i], exp);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("bp_out_valid", out_valid[i], 1'b1);
            check("bp_out_block", out_block[i], exp);
            check("bp_in_ready", in_ready[i], 1'b0);
            check("bp_rk_idx", rk_idx[i], 4'd0);
        end
        @(posedge clk); #2;
        out_ready[i] = 1'b1;
        @(posedge clk); #2;
        out_ready[i] = 1'b0;
    endtask

    initial begin
        int e, rise1, rise2;
        bit prev;
        logic [127:0] blk1, blk2;

        build_tables();
        expand_key(0, KEY_B, 4);
        check("model_appB", model_enc(PT_B, 0), CT_B);
        expand_key(0, KEY_C1, 4);
        check("model_c1", model_enc(PT_C, 0), CT_C1);
        expand_key(1, KEY_C3, 8);
        check("model_c3", model_enc(PT_C, 1), CT_C3);
        expand_key(0, KEY_B, 4);

        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready[0], 1'b1);
        check("rst_out_valid", out_valid[0], 1'b0);
        check("rst_out_block", out_block[0], 128'h0);
        check("rst_rk_idx", rk_idx[0], 4'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // App.B with 20-cycle backpressure
        start_block(0, PT_B);
        finish_block(0, CT_B, 20);
`ifdef AES_ROUND_ENGINE_DBG_EN
        check("dbg_round1_state", dbg_r1, 128'ha49c7ff2689f352b6b5bea43026a5049);
`endif

        expand_key(0, KEY_C1, 4);
        start_block(0, PT_C);
        finish_block(0, CT_C1, 0);

        start_block(1, PT_C);
        finish_block(1, CT_C3, 0);

        // Reset while round 5 is in flight
        expand_key(0, KEY_B, 4);
        start_block(0, PT_B);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_rk_idx", rk_idx[0], 4'd5);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid[0], 1'b0);
        check("mid_rst_out_block", out_block[0], 128'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        start_block(0, PT_B);
        finish_block(0, CT_B, 0);

        // Back-to-back: second block accepted on the handoff edge
        @(posedge clk); #2;
        in_valid[0] = 1'b1;
        in_block[0] = PT_B;
        out_ready[0] = 1'b1;
        e = 0; rise1 = 0; rise2 = 0; prev = 1'b0; blk1 = '0; blk2 = '0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            e++;
            #2;
            if (e == 1) in_block[0] = PT_C;
            if (e == 12) in_valid[0] = 1'b0;
            @(negedge clk);
            if (out_valid[0] && !prev) begin
                if (rise1 == 0) begin
                    rise1 = e; blk1 = out_block[0];
                end else if (rise2 == 0) begin
                    rise2 = e; blk2 = out_block[0];
                end
            end
            prev = out_valid[0];
        end
        out_ready[0] = 1'b0;
        check("b2b_first_edge", rise1, 11);
        check("b2b_second_edge", rise2, 22);
        check("b2b_first_block", blk1, CT_B);
        check("b2b_second_block", blk2, model_enc(PT_C, 0));

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
